mpx_readout_seq: RTL



---
 rtl/mpx_readout_pkg.sv | 25 ++
 rtl/mpx_readout_seq_clk_gen.sv | 39 +++
 rtl/mpx_readout_seq.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mpx_readout_pkg.sv
// Shared types and register map for the Medipix readout sequencer.
// Optional IRQ support is enabled with the MPX_READOUT_IRQ_EN macro.
package mpx_readout_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_LEN    = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_COUNT  = 2'd3;

    localparam int CTRL_START_BIT    = 0;
    localparam int CTRL_ABORT_BIT    = 1;
    localparam int STAT_BUSY_BIT     = 0;
    localparam int STAT_DONE_BIT     = 1;
    localparam int STAT_TIMEOUT_BIT  = 2;
    localparam int STAT_IRQ_MASK_BIT = 8;

endpackage

// File: rtl/mpx_readout_seq_clk_gen.sv
// Readout clock divider: mpx_clk toggles every CLK_DIV cycles while enabled,
// starting low; rise/fall strobe the cycle before the corresponding edge.
module mpx_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic mpx_clk,
    output logic rise,
    output logic fall
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt_reg;
    logic             tick;

    assign tick = enable && (div_cnt_reg == DIV_W'(CLK_DIV - 1));
    assign rise = tick && !mpx_clk && !clear;
    assign fall = tick &&  mpx_clk && !clear;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_reg <= '0;
            mpx_clk     <= 1'b0;
        end else if (!enable || clear) begin
            div_cnt_reg <= '0;
            mpx_clk     <= 1'b0;
        end else if (tick) begin
            div_cnt_reg <= '0;
            mpx_clk     <= !mpx_clk;
        end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
        end
    end

endmodule

// File: rtl/mpx_readout_seq.sv
// Medipix readout sequencer with Avalon-MM control; drives chip_busy to the PIO.
// Define MPX_READOUT_IRQ_EN to add the irq output and STATUS bit8 irq mask.
module mpx_readout_seq
    import mpx_readout_pkg::*;
#(
    parameter int CLK_DIV        = 4,
    parameter int SETUP_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int LEN_W          = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        mpx_eot_in,
    output logic        mpx_enable,
    output logic        mpx_clk_out,
    output logic        chip_busy,
`ifdef MPX_READOUT_IRQ_EN
    output logic        irq,
`endif
    output logic        done_pulse
);

    localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SETUP_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

    state_t             state_reg;
    logic [LEN_W-1:0]   len_reg;
    logic [LEN_W-1:0]   count_reg;
    logic [TMO_W-1:0]   tmo_cnt_reg;
    logic [SETUP_W-1:0] setup_cnt_reg;
    logic               done_reg;
    logic               timeout_reg;
    logic               eot_meta_reg;
    logic               eot_sync_reg;
    logic [31:0]        rd_next;

    logic wr_en, wr_ctrl, wr_len, wr_status;
    logic start_req, abort_req, abort_hit, tmo_hit;
    logic clk_rise, clk_fall;
    logic unused_wdata;

    assign wr_en     = chipselect && !write_n;
    assign wr_ctrl   = wr_en && (address == ADDR_CTRL);
    assign wr_len    = wr_en && (address == ADDR_LEN);
    assign wr_status = wr_en && (address == ADDR_STATUS);
    assign start_req = wr_ctrl && writedata[CTRL_START_BIT];
    assign abort_req = wr_ctrl && writedata[CTRL_ABORT_BIT];
    assign abort_hit = abort_req && (state_reg != IDLE);
    assign tmo_hit   = ((state_reg == SHIFT) || (state_reg == DRAIN)) &&
                       (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1));
    assign unused_wdata = ^writedata;

    // Stopping the divider on abort/timeout lets mpx_clk_out fall on the same edge as the FSM.
    mpx_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (state_reg == SHIFT),
        .clear   (abort_hit || tmo_hit),
        .mpx_clk (mpx_clk_out),
        .rise    (clk_rise),
        .fall    (clk_fall)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eot_meta_reg <= 1'b0;
            eot_sync_reg <= 1'b0;
        end else begin
            eot_meta_reg <= mpx_eot_in;
            eot_sync_reg <= eot_meta_reg;
        end
    end

    // The in-flight frame compares against len_reg, so it is frozen while busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_reg <= '0;
        end else if (wr_len && !chip_busy) begin
            len_reg <= writedata[LEN_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            tmo_cnt_reg   <= '0;
            setup_cnt_reg <= '0;
            done_reg      <= 1'b0;
            timeout_reg   <= 1'b0;
            mpx_enable    <= 1'b0;
            chip_busy     <= 1'b0;
            done_pulse    <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            if ((state_reg == SHIFT) || (state_reg == DRAIN)) begin
                tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
            end
            if (wr_status) begin
                done_reg    <= 1'b0;
                timeout_reg <= 1'b0;
            end
            if (abort_hit) begin
                state_reg  <= IDLE;
                mpx_enable <= 1'b0;
                chip_busy  <= 1'b0;
            end else if (tmo_hit) begin
                state_reg   <= IDLE;
                mpx_enable  <= 1'b0;
                chip_busy   <= 1'b0;
                timeout_reg <= 1'b1;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start_req && !abort_req && (len_reg != '0)) begin
                            state_reg     <= ARM;
                            mpx_enable    <= 1'b1;
                            chip_busy     <= 1'b1;
                            count_reg     <= '0;
                            done_reg      <= 1'b0;
                            timeout_reg   <= 1'b0;
                            setup_cnt_reg <= '0;
                            tmo_cnt_reg   <= '0;
                        end
                    end
                    ARM: begin
                        if (setup_cnt_reg == SETUP_W'(SETUP_CYCLES - 1)) begin
                            state_reg <= SHIFT;
                        end else begin
                            setup_cnt_reg <= setup_cnt_reg + SETUP_W'(1);
                        end
                    end
                    SHIFT: begin
                        if (clk_rise) begin
                            count_reg <= count_reg + LEN_W'(1);
                        end
                        if (clk_fall && (count_reg == len_reg)) begin
                            state_reg <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (eot_sync_reg) begin
                            state_reg  <= DONE;
                            done_pulse <= 1'b1;
                            done_reg   <= 1'b1;
                            mpx_enable <= 1'b0;
                            chip_busy  <= 1'b0;
                        end
                    end
                    DONE: begin
                        state_reg <= IDLE;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef MPX_READOUT_IRQ_EN
    logic irq_mask_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask_reg <= 1'b0;
        end else if (wr_status) begin
            irq_mask_reg <= writedata[STAT_IRQ_MASK_BIT];
        end
    end

    assign irq = irq_mask_reg && (done_reg || timeout_reg);
`endif

    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_LEN: begin
                rd_next[LEN_W-1:0] = len_reg;
            end
            ADDR_STATUS: begin
                rd_next[STAT_BUSY_BIT]    = chip_busy;
                rd_next[STAT_DONE_BIT]    = done_reg;
                rd_next[STAT_TIMEOUT_BIT] = timeout_reg;
`ifdef MPX_READOUT_IRQ_EN
                rd_next[STAT_IRQ_MASK_BIT] = irq_mask_reg;
`endif
            end
            ADDR_COUNT: begin
                rd_next[LEN_W-1:0] = count_reg;
            end
            default: begin
                rd_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_next;
        end
    end

endmodule
